// File: rtl/mdu_sequencer_pkg.sv
// MDU sequencer shared types and constants.
// Op/select encodings and default latencies.
package mdu_sequencer_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;

  localparam logic MDU_HI = 1'b1;
  localparam logic MDU_LO = 1'b0;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } mdu_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  function automatic logic is_mult(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// MDU datapath: combinational {hi,lo} from op/rs/rt.
// Unknown ops fall through to the unsigned divide.
module mdu_arith
  import mdu_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output mdu_res_t    res
);

  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic        w_is_mult;
  logic        w_is_multu;
  logic        w_is_div;
  logic        w_is_dz;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_is_mult  = (op == MDU_MULT);
  assign w_is_multu = (op == MDU_MULTU);
  assign w_is_div   = (op == MDU_DIV);
  assign w_is_dz    = ~w_is_mult & ~w_is_multu
                    & (rt == 32'd0);

  // Low 64 bits of the sign-extended product.
  assign w_smul = {{32{rs[31]}}, rs}
                * {{32{rt[31]}}, rt};
  assign w_umul = {32'd0, rs} * {32'd0, rt};

  // One unsigned divider on magnitudes; signs
  // restored after. INT_MIN/-1 wraps to INT_MIN.
  assign w_a  = (w_is_div & rs[31]) ? -rs : rs;
  assign w_b  = (w_is_div & rt[31]) ? -rt : rt;
  assign w_uq = w_a / w_b;
  assign w_ur = w_a % w_b;
  assign w_q  = (w_is_div & (rs[31] ^ rt[31]))
              ? -w_uq : w_uq;
  assign w_r  = (w_is_div & rs[31]) ? -w_ur : w_ur;

  // Result select, divide-by-zero overrides quotient.
  always_comb begin
    res = '0;
    unique case (1'b1)
      w_is_mult:  res = w_smul;
      w_is_multu: res = w_umul;
      w_is_dz:    res = {rs, 32'hFFFF_FFFF};
      default:    res = {w_r, w_q};
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// MDU sequencer: HI/LO owner, fixed-latency busy.
// Result latched at issue, committed on last cycle.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        we,
  input  logic        r_sel,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        req,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES)
                      ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  mdu_state_e  r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        w_idle;
  logic        w_go;
  logic        w_wr;
  mdu_res_t    w_res;

  mdu_arith u_arith (
    .op  (op),
    .rs  (rs_data),
    .rt  (rt_data),
    .res (w_res)
  );

  assign w_idle = (r_state == S_IDLE);
  assign w_go   = start & ~req & w_idle;
  assign w_wr   = we & ~start & ~req & w_idle;

  // Same-cycle busy so D stalls a dependent op.
  assign busy  = w_go | (r_state == S_RUN);
  assign rdata = (r_sel == MDU_HI) ? r_hi : r_lo;
  assign hi    = r_hi;
  assign lo    = r_lo;

  // Issue/countdown/commit FSM plus mthi/mtlo writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_pend_hi <= w_res.hi;
            r_pend_lo <= w_res.lo;
            r_cnt     <= is_mult(op)
                       ? CW'(MULT_CYCLES)
                       : CW'(DIV_CYCLES);
            r_state   <= S_RUN;
          end else if (w_wr) begin
            if (r_sel == MDU_HI) r_hi <= rs_data;
            else                 r_lo <= rs_data;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: cycle model + literals.
// Model tracks commit cycle and computes with longint.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic        we = 1'b0;
  logic        r_sel = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        req = 1'b0;
  logic        busy;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk = 0;
  int n_pass = 0;

  mdu_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .we      (we),
    .r_sel   (r_sel),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .req     (req),
    .busy    (busy),
    .rdata   (rdata),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h t=%0t",
                  nm, act, exp, $time);
  endtask

  // Reference arithmetic in 64-bit integers.
  function automatic logic [63:0] ref_res(
    input logic [3:0] o,
    input logic [31:0] a,
    input logic [31:0] b);
    longint sa, sb, ua, ub, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (o == MDU_MULT) return sa * sb;
    if (o == MDU_MULTU) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o == MDU_DIV) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Model state: committed regs and in-flight op.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_res = 64'd0;
  logic        m_act = 1'b0;
  int          m_done = 0;
  int          cyc = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi  <= 32'd0;
      m_lo  <= 32'd0;
      m_act <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_act) begin
        if (start || we)
          $display("note: protocol error, issue in RUN t=%0t",
                   $time);
        if (cyc == m_done) begin
          m_hi  <= m_res[63:32];
          m_lo  <= m_res[31:0];
          m_act <= 1'b0;
        end
      end else if (start && !req) begin
        m_res  <= ref_res(op, rs_data, rt_data);
        m_done <= cyc + (((op == MDU_MULT) ||
                          (op == MDU_MULTU)) ? 5 : 10);
        m_act  <= 1'b1;
      end else if (we && !req) begin
        if (r_sel == MDU_HI) m_hi <= rs_data;
        else                 m_lo <= rs_data;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy", {31'd0, busy},
          {31'd0, m_act | (start & ~req)});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("rdata", rdata, r_sel ? m_hi : m_lo);
    end
  end

  task automatic tick(input logic st,
                      input logic [3:0] o,
                      input logic w,
                      input logic sel,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic rq);
    start = st; op = o; we = w; r_sel = sel;
    rs_data = a; rt_data = b; req = rq;
    @(posedge clk); #1;
    start = 1'b0; we = 1'b0; req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    idle(1);

    // mult -2*3
    tick(1, MDU_MULT, 0, MDU_LO,
         32'hFFFF_FFFE, 32'd3, 0);
    idle(4);
    chk("mult_busy_t5", {31'd0, busy}, 32'd1);
    chk("mult_old_lo", rdata, 32'd0);
    idle(1);
    chk("mult_busy_t6", {31'd0, busy}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // multu same operands
    tick(1, MDU_MULTU, 0, MDU_HI,
         32'hFFFF_FFFE, 32'd3, 0);
    idle(5);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    // div -7/2
    tick(1, MDU_DIV, 0, MDU_LO,
         32'hFFFF_FFF9, 32'd2, 0);
    idle(9);
    chk("div_busy_t10", {31'd0, busy}, 32'd1);
    idle(1);
    chk("div_busy_t11", {31'd0, busy}, 32'd0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // divu by zero
    tick(1, MDU_DIVU, 0, MDU_HI,
         32'h0000_1234, 32'd0, 0);
    idle(10);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'h0000_1234);

    // INT_MIN / -1
    tick(1, MDU_DIV, 0, MDU_LO,
         32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(10);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // mthi, then mtlo flushed by req
    tick(0, MDU_MULT, 1, MDU_HI,
         32'hA5A5_A5A5, 32'd0, 0);
    chk("mthi", hi, 32'hA5A5_A5A5);
    tick(0, MDU_MULT, 1, MDU_LO,
         32'h1111_1111, 32'd0, 1);
    chk("mtlo_req", lo, 32'h8000_0000);

    // start flushed by req: no busy, no RUN
    start = 1'b1; op = MDU_MULT; req = 1'b1;
    rs_data = 32'd4; rt_data = 32'd4;
    #1;
    chk("req_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; req = 1'b0;
    chk("req_norun", {31'd0, busy}, 32'd0);

    // start during RUN is ignored
    tick(1, MDU_MULT, 0, MDU_LO, 32'd7, 32'd9, 0);
    idle(2);
    tick(1, MDU_DIVU, 0, MDU_LO, 32'd100, 32'd3, 0);
    idle(2);
    chk("ign_lo", lo, 32'd63);
    chk("ign_hi", hi, 32'd0);
    chk("ign_busy", {31'd0, busy}, 32'd0);

    // start and we together: start wins
    tick(1, MDU_MULT, 1, MDU_LO, 32'd5, 32'd6, 0);
    chk("sw_nowrite", lo, 32'd63);
    idle(5);
    chk("sw_lo", lo, 32'd30);

    // undefined op behaves as divu
    tick(1, 4'hF, 0, MDU_LO, 32'd100, 32'd7, 0);
    idle(10);
    chk("bad_lo", lo, 32'd14);
    chk("bad_hi", hi, 32'd2);

    // unsigned max product
    tick(1, MDU_MULTU, 0, MDU_HI,
         32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    idle(5);
    chk("umax_hi", hi, 32'hFFFF_FFFE);
    chk("umax_lo", lo, 32'h0000_0001);

    // reset mid-RUN
    tick(1, MDU_MULT, 0, MDU_LO, 32'd3, 32'd3, 0);
    idle(2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(8);
    r_sel = MDU_LO;
    #1;
    chk("post_rst_mflo", rdata, 32'd0);
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
